write_channel_arbiter: RTL and testbench

//  Shares one write-channel instance (IOb valid/addr/wdata/wstrb/ready) between N_REQ write requesters.

---
 rtl/write_channel_arbiter_pkg.sv | 21 ++
 rtl/write_channel_arbiter_rr_priority_select.sv | 40 ++++
 rtl/write_channel_arbiter.sv | 103 ++++++++++
 tb/tb_write_channel_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_channel_arbiter_pkg.sv
// Shared definitions for the write-channel arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE/ISSUE/WAIT/ACK)
//   wr_mode_t   : operating mode of the downstream write channel. The arbiter
//                 behaves the same in both modes. In write-back mode the channel
//                 drives ready=~valid while idle, so ISSUE must never wait on
//                 wr_ready.
package write_channel_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    MODE_WRITE_THROUGH = 1'b0,
    MODE_WRITE_BACK    = 1'b1
  } wr_mode_t;

endpackage

// File: rtl/write_channel_arbiter_rr_priority_select.sv
// Combinational round-robin selector.
//   req_valid   : per-requester request vector
//   last        : index of the most recent winner
//   grant_valid : at least one requester is valid
//   grant_idx   : first valid index strictly after last, wrapping modulo N_REQ
module rr_priority_select
  import write_channel_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  last,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_idx
);

  logic [2*N_REQ-1:0] doubled;
  logic [ID_W:0]      shamt;
  logic [N_REQ-1:0]   rotated;
  int unsigned        sel;
  int unsigned        sum;

  // Rotate so that index last+1 lands at bit 0, pick the lowest set bit,
  // then rotate the chosen position back into requester numbering.
  always_comb begin
    shamt       = {1'b0, last} + (ID_W+1)'(1);
    doubled     = {req_valid, req_valid};
    rotated     = N_REQ'(doubled >> shamt);
    grant_valid = |rotated;
    sel         = 0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      if (rotated[k-1]) sel = k - 1;
    end
    sum = 32'(shamt) + sel;
    if (sum >= N_REQ) sum = sum - N_REQ;
    grant_idx = ID_W'(sum);
  end

endmodule

// File: rtl/write_channel_arbiter.sv
// Shares one write channel between N_REQ requesters using round-robin
// arbitration. The winner's addr/wdata/wstrb are captured into hold registers
// that stay stable for the whole channel transaction; the winner gets a
// one-cycle req_ready pulse when the channel completes.
//   clk, reset  : clock (rising edge), asynchronous active-low reset
//   req_*       : packed per-requester request bundles, req_ready one-hot ack
//   wr_*        : single write-channel interface (wr_ready = completion in WAIT)
//   grant_id    : index of the current / last winner
//   busy        : high in any state other than IDLE
module write_channel_arbiter
  import write_channel_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_W-1:0]     req_addr,
  input  logic [N_REQ*DATA_W-1:0]     req_wdata,
  input  logic [N_REQ*(DATA_W/8)-1:0] req_wstrb,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        wr_valid,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_wdata,
  output logic [DATA_W/8-1:0]         wr_wstrb,
  input  logic                        wr_ready,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy
);

  localparam int NBYTES = DATA_W / 8;

  arb_state_t      state;
  logic [ID_W-1:0] last;
  logic            grant_valid;
  logic [ID_W-1:0] grant_idx;

  rr_priority_select #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_select (
    .req_valid   (req_valid),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      last      <= ID_W'(N_REQ - 1);
      grant_id  <= '0;
      req_ready <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_wdata  <= '0;
      wr_wstrb  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= '0;
          if (grant_valid) begin
            wr_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            wr_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
            wr_wstrb <= req_wstrb[grant_idx*NBYTES +: NBYTES];
            grant_id <= grant_idx;
            wr_valid <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        // Single-cycle valid, never gated on wr_ready: an idle write-back
        // channel reports ready even though it has not accepted anything.
        ST_ISSUE: begin
          wr_valid <= 1'b0;
          state    <= ST_WAIT;
        end
        // Error retries inside the channel keep wr_ready low; no timeout.
        ST_WAIT: begin
          if (wr_ready) begin
            last      <= grant_id;
            req_ready <= N_REQ'(1) << grant_id;
            state     <= ST_ACK;
          end
        end
        ST_ACK: begin
          req_ready <= '0;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= '0;
          wr_valid  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_channel_arbiter.sv
module tb_write_channel_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Two-requester instance
  logic [1:0]  req_valid2;
  logic [63:0] req_addr2, req_wdata2;
  logic [7:0]  req_wstrb2;
  logic [1:0]  req_ready2;
  logic        wr_valid2, wr_ready2, busy2;
  logic [31:0] wr_addr2, wr_wdata2;
  logic [3:0]  wr_wstrb2;
  logic [0:0]  grant_id2;

  // Three-requester instance
  logic [2:0]  req_valid3;
  logic [95:0] req_addr3, req_wdata3;
  logic [11:0] req_wstrb3;
  logic [2:0]  req_ready3;
  logic        wr_valid3, wr_ready3, busy3;
  logic [31:0] wr_addr3, wr_wdata3;
  logic [3:0]  wr_wstrb3;
  logic [1:0]  grant_id3;

  write_channel_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_addr(req_addr2),
    .req_wdata(req_wdata2), .req_wstrb(req_wstrb2), .req_ready(req_ready2),
    .wr_valid(wr_valid2), .wr_addr(wr_addr2), .wr_wdata(wr_wdata2),
    .wr_wstrb(wr_wstrb2), .wr_ready(wr_ready2), .grant_id(grant_id2), .busy(busy2));

  write_channel_arbiter #(.N_REQ(3), .ADDR_W(32), .DATA_W(32)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_addr(req_addr3),
    .req_wdata(req_wdata3), .req_wstrb(req_wstrb3), .req_ready(req_ready3),
    .wr_valid(wr_valid3), .wr_addr(wr_addr3), .wr_wdata(wr_wdata3),
    .wr_wstrb(wr_wstrb3), .wr_ready(wr_ready3), .grant_id(grant_id3), .busy(busy3));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: per-requester payloads and last winner index.
  logic [31:0] ma2[2], md2[2];
  logic [3:0]  ms2[2];
  logic [31:0] ma3[3];
  int m_last2, m_last3;

  // First valid requester after 'last', walking forward with wrap.
  function automatic int rr_pick(input int n, input int last, input logic [2:0] v);
    int idx;
    for (int k = 1; k <= n; k++) begin
      idx = (last + k) % n;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack2();
    for (int i = 0; i < 2; i++) begin
      req_addr2[i*32 +: 32]  = ma2[i];
      req_wdata2[i*32 +: 32] = md2[i];
      req_wstrb2[i*4 +: 4]   = ms2[i];
    end
  endtask

  task automatic rand_payload2(input int i);
    ma2[i] = $urandom;
    md2[i] = $urandom;
    ms2[i] = 4'($urandom);
    pack2();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid2 = '0;
    req_valid3 = '0;
    wr_ready2 = 1'b0;
    wr_ready3 = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    m_last2 = 1;
    m_last3 = 2;
    tick();
  endtask

  // Runs one channel transaction on dut2 and returns what was observed.
  task automatic obs2(input int wait_cyc, input bit rdy_issue, input bit auto_drop,
                      output bit ok, output int lat, output logic [0:0] gid,
                      output logic [31:0] a, output logic [31:0] d, output logic [3:0] s,
                      output int xv, output int eack, output logic [1:0] ack,
                      output logic [1:0] acka, output logic busya);
    ok = 1'b0; lat = 0; gid = '0; a = '0; d = '0; s = '0;
    xv = 0; eack = 0; ack = '0; acka = '0; busya = 1'b1;
    while (!ok && lat < 20) begin
      tick();
      lat++;
      ok = wr_valid2;
    end
    if (!ok) return;
    gid = grant_id2; a = wr_addr2; d = wr_wdata2; s = wr_wstrb2;
    if (rdy_issue) wr_ready2 = 1'b1;
    tick();
    wr_ready2 = 1'b0;
    for (int i = 0; i <= wait_cyc; i++) begin
      if (wr_valid2) xv++;
      if (req_ready2 != 2'b00) eack++;
      if (i < wait_cyc) tick();
    end
    wr_ready2 = 1'b1;
    tick();
    wr_ready2 = 1'b0;
    ack = req_ready2;
    if (auto_drop) req_valid2[gid] = 1'b0;
    tick();
    acka = req_ready2;
    busya = busy2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid2 = '0; req_valid3 = '0; wr_ready2 = 1'b0; wr_ready3 = 1'b0;
    req_addr2 = '0; req_wdata2 = '0; req_wstrb2 = '0;
    req_addr3 = '0; req_wdata3 = '0; req_wstrb3 = '0;
    repeat (2) tick();
    n_cmp++;
    if ({wr_valid2, req_ready2, busy2, grant_id2} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl2: got %b expected 00000", {wr_valid2, req_ready2, busy2, grant_id2});
    end
    n_cmp++;
    if ({wr_addr2, wr_wdata2, wr_wstrb2} !== 68'b0) begin
      n_bad++; $display("FAIL reset_hold2: got %h expected 0", {wr_addr2, wr_wdata2, wr_wstrb2});
    end
    n_cmp++;
    if ({wr_valid3, req_ready3, busy3, grant_id3, wr_addr3} !== 39'b0) begin
      n_bad++; $display("FAIL reset_dut3: got %h expected 0", {wr_valid3, req_ready3, busy3, grant_id3, wr_addr3});
    end
    reset = 1'b1;
    m_last2 = 1;
    m_last3 = 2;
  endtask

  task automatic test_single();
    bit ok; int lat, xv, eack; logic [0:0] gid; logic [31:0] a, d; logic [3:0] s;
    logic [1:0] ack, acka; logic busya;
    ma2[0] = 32'h100; md2[0] = 32'hA5A5A5A5; ms2[0] = 4'hF;
    ma2[1] = $urandom; md2[1] = $urandom; ms2[1] = 4'($urandom);
    pack2();
    req_valid2 = 2'b01;
    obs2(3, 1'b0, 1'b1, ok, lat, gid, a, d, s, xv, eack, ack, acka, busya);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL single_latency: got %0d expected 1", lat); end
    n_cmp++; if (gid !== 1'b0) begin n_bad++; $display("FAIL single_gid: got %0d expected 0", gid); end
    n_cmp++;
    if ({a, d, s} !== {32'h100, 32'hA5A5A5A5, 4'hF}) begin
      n_bad++; $display("FAIL single_payload: got %h expected %h", {a, d, s}, {32'h100, 32'hA5A5A5A5, 4'hF});
    end
    n_cmp++; if (xv !== 0) begin n_bad++; $display("FAIL single_one_valid: got %0d extra expected 0", xv); end
    n_cmp++; if (eack !== 0) begin n_bad++; $display("FAIL single_early_ack: got %0d expected 0", eack); end
    n_cmp++; if (ack !== 2'b01) begin n_bad++; $display("FAIL single_ack: got %b expected 01", ack); end
    n_cmp++;
    if ({acka, busya} !== 3'b000) begin
      n_bad++; $display("FAIL single_after: got %b expected 000", {acka, busya});
    end
    m_last2 = 0;
  endtask

  task automatic test_simultaneous();
    bit ok; int lat, xv, eack, exp, pulses; logic [0:0] gid; logic [31:0] a, d; logic [3:0] s;
    logic [1:0] ack, acka; logic busya;
    do_reset();
    rand_payload2(0);
    rand_payload2(1);
    req_valid2 = 2'b11;
    pulses = 0;
    for (int t = 0; t < 2; t++) begin
      exp = rr_pick(2, m_last2, {1'b0, req_valid2});
      obs2(2, 1'b0, 1'b1, ok, lat, gid, a, d, s, xv, eack, ack, acka, busya);
      pulses += int'(ok) + xv;
      n_cmp++;
      if (gid !== 1'(exp)) begin n_bad++; $display("FAIL simul_gid%0d: got %0d expected %0d", t, gid, exp); end
      n_cmp++;
      if ({a, d, s} !== {ma2[exp], md2[exp], ms2[exp]}) begin
        n_bad++; $display("FAIL simul_payload%0d: got %h expected %h", t, {a, d, s}, {ma2[exp], md2[exp], ms2[exp]});
      end
      n_cmp++;
      if (ack !== 2'(1 << exp)) begin n_bad++; $display("FAIL simul_ack%0d: got %b expected %b", t, ack, 2'(1 << exp)); end
      m_last2 = exp;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_valid2) pulses++;
    end
    n_cmp++;
    if (pulses !== 2) begin n_bad++; $display("FAIL simul_pulses: got %0d expected 2", pulses); end
  endtask

  task automatic test_round_robin();
    bit ok; int lat, xv, eack, exp; logic [0:0] gid; logic [31:0] a, d; logic [3:0] s;
    logic [1:0] ack, acka; logic busya;
    req_valid2 = 2'b11;
    for (int t = 0; t < 6; t++) begin
      exp = rr_pick(2, m_last2, {1'b0, req_valid2});
      obs2(t % 3, 1'b0, 1'b0, ok, lat, gid, a, d, s, xv, eack, ack, acka, busya);
      n_cmp++;
      if (gid !== 1'(exp)) begin n_bad++; $display("FAIL rr_gid%0d: got %0d expected %0d", t, gid, exp); end
      n_cmp++;
      if ({ack, acka} !== {2'(1 << exp), 2'b00}) begin
        n_bad++; $display("FAIL rr_ack%0d: got %b expected %b", t, {ack, acka}, {2'(1 << exp), 2'b00});
      end
      m_last2 = exp;
    end
    req_valid2 = 2'b00;
    tick();
  endtask

  task automatic test_ready_in_issue();
    bit ok; int lat, xv, eack, exp; logic [0:0] gid; logic [31:0] a, d; logic [3:0] s;
    logic [1:0] ack, acka; logic busya;
    rand_payload2(1);
    req_valid2 = 2'b10;
    exp = rr_pick(2, m_last2, {1'b0, req_valid2});
    obs2(4, 1'b1, 1'b1, ok, lat, gid, a, d, s, xv, eack, ack, acka, busya);
    n_cmp++; if (eack !== 0) begin n_bad++; $display("FAIL issue_ready_ignored: got %0d early acks expected 0", eack); end
    n_cmp++;
    if ({gid, ack} !== {1'(exp), 2'(1 << exp)}) begin
      n_bad++; $display("FAIL issue_ready_grant: got %b expected %b", {gid, ack}, {1'(exp), 2'(1 << exp)});
    end
    m_last2 = exp;
  endtask

  task automatic test_hold_stable();
    bit seen; int n; logic [67:0] exp_hold;
    ma2[0] = $urandom; md2[0] = $urandom; ms2[0] = 4'($urandom);
    pack2();
    exp_hold = {ma2[0], md2[0], ms2[0]};
    req_valid2 = 2'b01;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin tick(); n++; seen = wr_valid2; end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL hold_issue: got no wr_valid expected one"); end
    tick();
    for (int i = 0; i < 50; i++) begin
      req_valid2[1] = 1'($urandom);
      req_addr2[63:32] = $urandom;
      req_wdata2[63:32] = $urandom;
      req_wstrb2[7:4] = 4'($urandom);
      tick();
      n_cmp++;
      if ({wr_valid2, req_ready2, wr_addr2, wr_wdata2, wr_wstrb2} !== {3'b000, exp_hold}) begin
        n_bad++; $display("FAIL hold_cycle%0d: got %h expected %h", i,
                          {wr_valid2, req_ready2, wr_addr2, wr_wdata2, wr_wstrb2}, {3'b000, exp_hold});
      end
    end
    req_valid2[1] = 1'b0;
    wr_ready2 = 1'b1;
    tick();
    wr_ready2 = 1'b0;
    n_cmp++; if (req_ready2 !== 2'b01) begin n_bad++; $display("FAIL hold_ack: got %b expected 01", req_ready2); end
    req_valid2 = 2'b00;
    m_last2 = 0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bit ok, seen; int n, lat, xv, eack; logic [0:0] gid; logic [31:0] a, d; logic [3:0] s;
    logic [1:0] ack, acka; logic busya;
    rand_payload2(0);
    req_valid2 = 2'b01;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin tick(); n++; seen = wr_valid2; end
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({wr_valid2, req_ready2, busy2, grant_id2, wr_addr2, wr_wdata2, wr_wstrb2} !== 73'b0) begin
      n_bad++; $display("FAIL rstwait_async: got %h expected 0",
                        {wr_valid2, req_ready2, busy2, grant_id2, wr_addr2, wr_wdata2, wr_wstrb2});
    end
    req_valid2 = 2'b00;
    tick();
    n_cmp++;
    if ({wr_valid2, req_ready2, busy2} !== 4'b0) begin
      n_bad++; $display("FAIL rstwait_held: got %b expected 0000", {wr_valid2, req_ready2, busy2});
    end
    m_last2 = 1;
    m_last3 = 2;
    rand_payload2(1);
    req_valid2 = 2'b10;
    reset = 1'b1;
    obs2(1, 1'b0, 1'b1, ok, lat, gid, a, d, s, xv, eack, ack, acka, busya);
    n_cmp++;
    if ({gid, a, d, s, ack} !== {1'b1, ma2[1], md2[1], ms2[1], 2'b10}) begin
      n_bad++; $display("FAIL rstwait_regrant: got %h expected %h", {gid, a, d, s, ack},
                        {1'b1, ma2[1], md2[1], ms2[1], 2'b10});
    end
    m_last2 = 1;
  endtask

  task automatic test_three();
    bit seen; int n, exp;
    for (int i = 0; i < 3; i++) begin
      ma3[i] = $urandom;
      req_addr3[i*32 +: 32] = ma3[i];
    end
    req_wdata3 = '0;
    req_wstrb3 = '1;
    req_valid3 = 3'b001;
    for (int t = 0; t < 3; t++) begin
      exp = rr_pick(3, m_last3, req_valid3);
      seen = 1'b0; n = 0;
      while (!seen && n < 20) begin tick(); n++; seen = wr_valid3; end
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL three_issue%0d: got no wr_valid expected one", t); end
      n_cmp++;
      if ({grant_id3, wr_addr3} !== {2'(exp), ma3[exp]}) begin
        n_bad++; $display("FAIL three_grant%0d: got %h expected %h", t, {grant_id3, wr_addr3}, {2'(exp), ma3[exp]});
      end
      tick();
      tick();
      wr_ready3 = 1'b1;
      tick();
      wr_ready3 = 1'b0;
      n_cmp++;
      if (req_ready3 !== 3'(1 << exp)) begin
        n_bad++; $display("FAIL three_ack%0d: got %b expected %b", t, req_ready3, 3'(1 << exp));
      end
      m_last3 = exp;
      if (t == 0) req_valid3 = 3'b101;
      else req_valid3[exp] = 1'b0;
      tick();
    end
  endtask

  task automatic test_random();
    bit ok; int lat, xv, eack, exp; logic [0:0] gid; logic [31:0] a, d; logic [3:0] s;
    logic [1:0] ack, acka; logic busya;
    rand_payload2(0);
    rand_payload2(1);
    req_valid2 = 2'($urandom_range(1, 3));
    for (int t = 0; t < 25; t++) begin
      exp = rr_pick(2, m_last2, {1'b0, req_valid2});
      obs2(int'($urandom_range(0, 4)), 1'($urandom), 1'b0, ok, lat, gid, a, d, s, xv, eack, ack, acka, busya);
      n_cmp++;
      if (!ok || lat !== 1) begin n_bad++; $display("FAIL rand_lat%0d: got ok=%0d lat=%0d expected ok=1 lat=1", t, ok, lat); end
      n_cmp++;
      if ({gid, a, d, s} !== {1'(exp), ma2[exp], md2[exp], ms2[exp]}) begin
        n_bad++; $display("FAIL rand_grant%0d: got %h expected %h", t, {gid, a, d, s},
                          {1'(exp), ma2[exp], md2[exp], ms2[exp]});
      end
      n_cmp++;
      if ({xv, eack} !== {32'd0, 32'd0}) begin
        n_bad++; $display("FAIL rand_wait%0d: got xv=%0d eack=%0d expected 0 0", t, xv, eack);
      end
      n_cmp++;
      if ({ack, acka, busya} !== {2'(1 << exp), 3'b000}) begin
        n_bad++; $display("FAIL rand_ack%0d: got %b expected %b", t, {ack, acka, busya}, {2'(1 << exp), 3'b000});
      end
      m_last2 = exp;
      req_valid2[exp] = 1'($urandom);
      rand_payload2(exp);
      if (req_valid2 == 2'b00) req_valid2 = 2'($urandom_range(1, 3));
    end
    req_valid2 = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_ready_in_issue();
    test_hold_stable();
    test_reset_mid_wait();
    test_three();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
